// File: rtl/fetch_queue.sv
// Prefetch queue between instruction memory and IF/ID: owns the fetch PC, buffers fetched
// {instr, pc+4} pairs, flushes on EX redirect. Optional drop counter: FETCH_QUEUE_STATS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IM_Addr,
  input  logic [31:0] IM_Instr,
  output logic [31:0] Out_Instr,
  output logic [31:0] Out_NextAddress,
  output logic        Out_Valid,
  input  logic        Out_Ready
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0] Discarded
`endif
);

  localparam logic [PTR_W:0] CountFull = DEPTH[PTR_W:0];

  logic [31:0]    r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0] r_count;
  logic [63:0]    r_mem [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_fetch_pc_d;
  logic [PTR_W-1:0] w_rd_ptr_d;
  logic [PTR_W-1:0] w_wr_ptr_d;
  logic [PTR_W:0]   w_count_d;
  logic [63:0]      w_head;

  assign w_full     = (r_count == CountFull);
  assign w_pc_plus4 = r_fetch_pc + 32'd4;

  // Flush voids any handshake in its cycle, so neither pop nor push may fire.
  assign w_pop  = Out_Valid & Out_Ready & ~Flush;
  assign w_push = ~Flush & (~w_full | w_pop);

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    w_rd_ptr_d   = r_rd_ptr;
    w_wr_ptr_d   = r_wr_ptr;
    w_count_d    = r_count;
    if (Flush) begin
      w_fetch_pc_d = RedirectPC;
      w_rd_ptr_d   = '0;
      w_wr_ptr_d   = '0;
      w_count_d    = '0;
    end else begin
      if (w_push) begin
        w_fetch_pc_d = w_pc_plus4;
        w_wr_ptr_d   = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + (PTR_W + 1)'(1);
        2'b01:   w_count_d = r_count - (PTR_W + 1)'(1);
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_wr_ptr   <= w_wr_ptr_d;
      r_count    <= w_count_d;
    end
  end

  // Storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge Clk) begin
    if (!Reset && w_push) begin
      r_mem[r_wr_ptr] <= {IM_Instr, w_pc_plus4};
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign IM_Addr         = r_fetch_pc;
  assign Out_Valid       = (r_count != '0);
  assign Out_Instr       = Out_Valid ? w_head[63:32] : 32'h0;
  assign Out_NextAddress = Out_Valid ? w_head[31:0]  : 32'h0;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] r_discarded;
  logic [16:0] w_disc_sum;
  logic [15:0] w_discarded_d;

  assign w_disc_sum = {1'b0, r_discarded} + {{(16 - PTR_W){1'b0}}, r_count};

  always_comb begin
    w_discarded_d = r_discarded;
    if (Flush) begin
      w_discarded_d = w_disc_sum[16] ? 16'hFFFF : w_disc_sum[15:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_discarded <= '0;
    end else begin
      r_discarded <= w_discarded_d;
    end
  end

  assign Discarded = r_discarded;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/hold, streaming, flush, reset priority and PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] out_instr;
  logic [31:0] out_na;
  logic        out_valid;
  logic        out_ready;

  logic        reset_w;
  logic        flush_w = 1'b0;
  logic        ready_w = 1'b1;
  logic [31:0] redirect_w = 32'h0;
  logic [31:0] im_addr_w;
  logic [31:0] im_instr_w;
  logic [31:0] out_instr_w;
  logic [31:0] out_na_w;
  logic        out_valid_w;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] discarded;
  logic [15:0] discarded_w;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word content is its address with bits 15 and 13 set.
  assign im_instr   = im_addr | 32'hA000;
  assign im_instr_w = im_addr_w | 32'hA000;

  fetch_queue u_dut (
    .Clk             (clk),
    .Reset           (reset),
    .Flush           (flush),
    .RedirectPC      (redirect_pc),
    .IM_Addr         (im_addr),
    .IM_Instr        (im_instr),
    .Out_Instr       (out_instr),
    .Out_NextAddress (out_na),
    .Out_Valid       (out_valid),
    .Out_Ready       (out_ready)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .Discarded       (discarded)
`endif
  );

  fetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .Clk             (clk),
    .Reset           (reset_w),
    .Flush           (flush_w),
    .RedirectPC      (redirect_w),
    .IM_Addr         (im_addr_w),
    .IM_Instr        (im_instr_w),
    .Out_Instr       (out_instr_w),
    .Out_NextAddress (out_na_w),
    .Out_Valid       (out_valid_w),
    .Out_Ready       (ready_w)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .Discarded       (discarded_w)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    reset       = 1'b1;
    flush       = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    reset_w     = 1'b1;

    step();
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_addr", im_addr, 32'h0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_na", out_na, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
    check_eq("rst_disc", {16'b0, discarded}, 32'd0);
`endif

    // Fill with no consumer: one word per cycle, visible one cycle after fetch.
    reset = 1'b0;
    step();
    check_eq("t1_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t1_addr1", im_addr, 32'h4);
    check_eq("t1_instr", out_instr, 32'hA000);
    check_eq("t1_na", out_na, 32'h4);
    repeat (3) step();
    check_eq("t1_full_addr", im_addr, 32'h10);
    repeat (2) step();
    check_eq("t1_hold_addr", im_addr, 32'h10);
    check_eq("t1_hold_instr", out_instr, 32'hA000);
    check_eq("t1_hold_na", out_na, 32'h4);

    // Continuous consumer: one word per cycle, in order.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("t2_valid", {31'b0, out_valid}, 32'd1);
      check_eq("t2_na", out_na, 32'(4 + 4 * k));
      check_eq("t2_instr", out_instr, 32'(4 * k) | 32'hA000);
      step();
    end

    // Mid-run reset, then build Count=3 and flush to 0x40.
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t3_rst_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) step();
    check_eq("t3_pre_addr", im_addr, 32'hC);
    flush       = 1'b1;
    redirect_pc = 32'h40;
    step();
    flush = 1'b0;
    check_eq("t3_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t3_addr", im_addr, 32'h40);
    check_eq("t3_instr", out_instr, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
    check_eq("t3_disc", {16'b0, discarded}, 32'd3);
`endif
    step();
    check_eq("t3_valid2", {31'b0, out_valid}, 32'd1);
    check_eq("t3_na", out_na, 32'h44);
    check_eq("t3_instr2", out_instr, 32'hA040);

    // Flush with a simultaneous handshake: the handshake is void.
    repeat (2) step();
    check_eq("t4_pre_addr", im_addr, 32'h4C);
    flush       = 1'b1;
    out_ready   = 1'b1;
    redirect_pc = 32'h200;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    check_eq("t4_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t4_addr", im_addr, 32'h200);
`ifdef FETCH_QUEUE_STATS_EN
    check_eq("t4_disc", {16'b0, discarded}, 32'd6);
`endif
    step();
    check_eq("t4_na", out_na, 32'h204);
    check_eq("t4_instr", out_instr, 32'hA200);

    // Fill again, then Reset and Flush together: Reset wins.
    repeat (3) step();
    check_eq("t5_full_addr", im_addr, 32'h210);
    repeat (2) step();
    check_eq("t5_hold_addr", im_addr, 32'h210);
    check_eq("t5_hold_na", out_na, 32'h204);
    reset       = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'h80;
    step();
    reset = 1'b0;
    flush = 1'b0;
    check_eq("t5_addr", im_addr, 32'h0);
    check_eq("t5_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t5_na", out_na, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
    check_eq("t5_disc", {16'b0, discarded}, 32'd0);
`endif
    step();
    check_eq("t5_na2", out_na, 32'h4);

    // PC wrap at 2^32 with a free-running consumer; pointers wrap several times.
    check_eq("t6_rst_addr", im_addr_w, 32'hFFFF_FFF8);
    check_eq("t6_rst_valid", {31'b0, out_valid_w}, 32'd0);
    reset_w = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      check_eq("t6_valid", {31'b0, out_valid_w}, 32'd1);
      check_eq("t6_addr", im_addr_w, e);
      check_eq("t6_na", out_na_w, e);
      check_eq("t6_instr", out_instr_w, (e - 32'd4) | 32'hA000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
